dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Two-port arbiter and access sequencer for the single-port word-organised data memory. It accepts byte-addressed load/store requests from the core LSU (port 0) and the debug/loader port (port 1), arbitrates round-robin, and drives the memory's enable, write, address and data lines. It performs read-modify-write for sub-word stores and rejects misaligned or out-of-range accesses. Sits between the LSU/debug logic and the data memory instance.

## Interface
- `DEPTH`, 20, number of 32-bit words in the memory
- `AW`, 5, memory word-index width, must satisfy 2**AW >= DEPTH
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  one clock; reset is asynchronous and active-high
- `pN_req`  in  1  request from port N (N = 0, 1); held until `pN_gnt`
- `pN_we`  in  1  1 = store, 0 = load
- `pN_be`  in  4  byte enables for stores; bit i selects `wdata[8i+7:8i]`; ignored for loads
- `pN_addr`  in  32  byte address
- `pN_wdata`  in  32  store data
- `pN_gnt`  out  1  request accepted this cycle; request inputs may change next cycle
- `pN_rvalid`  out  1  one-cycle load response strobe
- `pN_rdata`  out  32  load data, valid with `pN_rvalid`, 0 otherwise
- `pN_err`  out  1  one-cycle error strobe for a rejected access
- `mem_en`  out  1  memory access this cycle
- `mem_we`  out  1  write when `mem_en`, read otherwise
- `mem_addr`  out  AW  word index (`addr[AW+1:2]`)
- `mem_wdata`  out  32  write data
- `mem_rdata`  in  32  read data, valid the cycle after a read issue (registered memory)

## Operation
- FSM states: IDLE, RD_RSP, RMW_WR, ERR_RSP. A grant is given only in IDLE.
- IDLE, no request: all outputs 0.
- IDLE, request(s): the arbiter picks a winner and asserts its `gnt` combinationally. The access is classified as follows.
  - Error, if `addr[1:0] != 0` or word index >= DEPTH: no memory access; → ERR_RSP.
  - Load: `mem_en=1`, `mem_we=0`; latch port id; → RD_RSP.
  - Store with `be == 4'hF`: `mem_en=1`, `mem_we=1`, `mem_wdata = wdata`; stay in IDLE.
  - Store with `be == 4'h0`: no memory access, no response; stay in IDLE.
  - Store with partial `be`: issue a read of the word; latch addr, be, wdata and port id; → RMW_WR.
- RD_RSP: latched port gets `rvalid=1` and `rdata = mem_rdata`; → IDLE.
- RMW_WR: `mem_en=1`, `mem_we=1`. Byte i of the written word is `wdata` byte i if `be[i]`, else `mem_rdata` byte i. → IDLE. No response strobe.
- ERR_RSP: latched port gets `err=1`. `rvalid` is also 1 if the rejected access was a load, with `rdata=0`. → IDLE.
- Arbitration: 2-way round-robin.
  - Priority pointer resets to port 0.
  - On every grant, the pointer moves to the non-granted port.
  - A single requester always wins.
- Only one port's `gnt`/`rvalid`/`err` is ever high in a cycle.

## Timing
- Reset values: every `gnt`, `rvalid`, `rdata`, `err`, `mem_*` output is 0; state is IDLE; pointer is 0. `gnt` is forced 0 while `rst` is high.
- Load: gnt at T, read issued at T, `rvalid` at T+1, next grant no earlier than T+2.
- Full store: gnt and write at T; next grant at T+1 (back-to-back stores, one per cycle).
- Partial store: gnt and read at T, merged write at T+1, next grant at T+2.
- Error: gnt at T, `err` at T+1, next grant at T+2.
- Reset mid-operation (RD_RSP/RMW_WR/ERR_RSP): response or RMW write is dropped, memory is not written, FSM returns to IDLE.
- Simultaneous requests in IDLE: the pointed-to port wins. The loser keeps `req` high and is granted at the next IDLE cycle.
- A port dropping `req` without a grant is legal; nothing happens.

## Structure
- Package `dmem_pkg`:
  - state enum `dmem_state_t`
  - constants `DMEM_DEPTH=20`, `DMEM_AW=5`
  - function `be_merge(old, new, be)`
- Sub-module `dmem_rr_arb`: 2-way round-robin arbiter.
  - Inputs: `req[1:0]`, `en` (FSM in IDLE).
  - Outputs: one-hot `gnt[1:0]`; owns the priority pointer.

## Test plan
- Port 0 full store `addr=0x8`, `wdata=0xDEADBEEF`, `be=F`, then load `0x8` → `mem_we` at T with index 2; load `p0_rvalid` at T+1 with `rdata=0xDEADBEEF`.
- Preload word 3 = `0x11223344`; port 1 store `addr=0xC`, `be=4'b0101`, `wdata=0xAABBCCDD` → T+1 write `0x11BB33DD`; readback returns `0x11BB33DD`.
- Both ports request loads every cycle from reset → grants alternate p0, p1, p0, …, with each `rvalid` on the matching port.
- Port 0 load `addr=0x50` (index 20) → no `mem_en`; T+1 `p0_err=1`, `p0_rvalid=1`, `rdata=0`. Port 1 store `addr=0x6` → `p1_err=1`, `rvalid=0`.
- Store with `be=0` → `gnt` high, no `mem_en`, FSM stays IDLE, next request granted the following cycle.
- Assert `rst` in the RMW_WR cycle of a partial store → no memory write, all outputs 0. After release, a load of that word returns the unmodified value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, constants and byte-merge helper for the data-memory
// access sequencer.
package dmem_pkg;

  localparam int DMEM_DEPTH = 20;
  localparam int DMEM_AW    = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_RSP,
    ST_RMW_WR,
    ST_ERR_RSP
  } dmem_state_t;

  // Byte i comes from new_word when be[i] is set, otherwise from old_word.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// One requester's load/store channel into the data-memory controller.
// The requester drives the master side; the controller takes the slave side.
interface dmem_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, be, addr, wdata,
                  input  gnt, rvalid, rdata, err);
  modport slave  (input  req, we, be, addr, wdata,
                  output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// pointed-to port wins and the pointer then moves to the other port.
module dmem_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr <= 1'b0;
    else if (|gnt) ptr <= gnt[0];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Arbitrates LSU (p0) and debug (p1) byte-addressed requests onto a
// single-port registered word memory, with read-modify-write for partial stores.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = DMEM_AW
) (
  input  logic          clk,
  input  logic          rst,
  dmem_if.slave         p0,
  dmem_if.slave         p1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  dmem_state_t   state;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          arb_en;
  logic          sel_we;
  logic          sel_bad;
  logic [3:0]    sel_be;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic          lat_port;
  logic          lat_load;
  logic [AW-1:0] lat_addr;
  logic [3:0]    lat_be;
  logic [31:0]   lat_wdata;
  logic          rsp_valid;
  logic          rsp_err;
  logic [31:0]   rsp_data;

  assign req    = {p1.req, p0.req};
  assign arb_en = (state == ST_IDLE) && !rst;

  dmem_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign sel_we    = gnt[1] ? p1.we    : p0.we;
  assign sel_be    = gnt[1] ? p1.be    : p0.be;
  assign sel_addr  = gnt[1] ? p1.addr  : p0.addr;
  assign sel_wdata = gnt[1] ? p1.wdata : p0.wdata;

  // The whole word index is range-checked, so high address bits cannot alias.
  assign sel_bad = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= DEPTH_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_port  <= 1'b0;
      lat_load  <= 1'b0;
      lat_addr  <= '0;
      lat_be    <= 4'h0;
      lat_wdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            lat_port  <= gnt[1];
            lat_load  <= !sel_we;
            lat_addr  <= sel_addr[AW+1:2];
            lat_be    <= sel_be;
            lat_wdata <= sel_wdata;
            if (sel_bad)                              state <= ST_ERR_RSP;
            else if (!sel_we)                         state <= ST_RD_RSP;
            else if (sel_be != 4'hF && sel_be != 4'h0) state <= ST_RMW_WR;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = 32'h0;
    case (state)
      ST_IDLE: begin
        if ((|gnt) && !sel_bad && !(sel_we && sel_be == 4'h0)) begin
          mem_en   = 1'b1;
          mem_addr = sel_addr[AW+1:2];
          if (sel_we && sel_be == 4'hF) begin
            mem_we    = 1'b1;
            mem_wdata = sel_wdata;
          end
        end
      end
      ST_RD_RSP: begin
        rsp_valid = 1'b1;
        rsp_data  = mem_rdata;
      end
      ST_RMW_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = lat_addr;
        mem_wdata = be_merge(mem_rdata, lat_wdata, lat_be);
      end
      ST_ERR_RSP: begin
        rsp_err   = 1'b1;
        rsp_valid = lat_load;
      end
      default: ;
    endcase
  end

  assign p0.gnt    = gnt[0];
  assign p1.gnt    = gnt[1];
  assign p0.rvalid = rsp_valid && !lat_port;
  assign p1.rvalid = rsp_valid && lat_port;
  assign p0.err    = rsp_err && !lat_port;
  assign p1.err    = rsp_err && lat_port;
  assign p0.rdata  = (rsp_valid && !lat_port) ? rsp_data : 32'h0;
  assign p1.rdata  = (rsp_valid && lat_port)  ? rsp_data : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a transaction-level model.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  dmem_if p0_if ();
  dmem_if p1_if ();

  dmem_ctrl #(.DEPTH(20), .AW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .p0        (p0_if),
    .p1        (p1_if),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Registered word memory; preload overrides any write on the same edge.
  logic [31:0] tb_mem      [0:31];
  logic [31:0] preload_img [0:31];
  logic        preload = 1'b0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) tb_mem[i] <= preload_img[i];
    end else if (mem_en && mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
    if (mem_en && !mem_we) mem_rdata <= tb_mem[mem_addr];
  end

  typedef struct {
    string       name;
    bit          port;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          t0_en;
    bit          t0_we;
    bit          t1_en;
    logic [31:0] t1_wdata;
    bit          t1_rvalid;
    bit          t1_err;
    logic [31:0] t1_rdata;
  } vec_t;

  vec_t vecs[$];

  // Random-phase model state.
  logic [31:0] ref_mem [0:31];
  bit          p_act   [2];
  bit          p_we    [2];
  logic [3:0]  p_be    [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wdata [2];
  bit          pref;
  int          cyc;
  int          busy_until;
  bit          r_pend;
  bit          r_port;
  bit          r_valid;
  bit          r_err;
  logic [31:0] r_data;
  bit [1:0]    exp_g;
  int          w;
  logic [31:0] idx;
  logic [31:0] mask;
  bit          bad;

  function automatic vec_t mkVec(string name, bit port, bit we, logic [3:0] be,
                                 logic [31:0] addr, logic [31:0] wdata,
                                 bit t0_en, bit t0_we, bit t1_en, logic [31:0] t1_wdata,
                                 bit t1_rvalid, bit t1_err, logic [31:0] t1_rdata);
    vec_t v;
    v.name = name;   v.port = port;   v.we = we;       v.be = be;
    v.addr = addr;   v.wdata = wdata; v.t0_en = t0_en; v.t0_we = t0_we;
    v.t1_en = t1_en; v.t1_wdata = t1_wdata;
    v.t1_rvalid = t1_rvalid; v.t1_err = t1_err; v.t1_rdata = t1_rdata;
    return v;
  endfunction

  function automatic logic portGnt(input bit port);
    return port ? p1_if.gnt : p0_if.gnt;
  endfunction
  function automatic logic portRvalid(input bit port);
    return port ? p1_if.rvalid : p0_if.rvalid;
  endfunction
  function automatic logic portErr(input bit port);
    return port ? p1_if.err : p0_if.err;
  endfunction
  function automatic logic [31:0] portRdata(input bit port);
    return port ? p1_if.rdata : p0_if.rdata;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drivePort(input bit port, input bit req, input bit we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      p1_if.req = req; p1_if.we = we; p1_if.be = be; p1_if.addr = addr; p1_if.wdata = wdata;
    end else begin
      p0_if.req = req; p0_if.we = we; p0_if.be = be; p0_if.addr = addr; p0_if.wdata = wdata;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk); #1;
    drivePort(v.port, 1'b1, v.we, v.be, v.addr, v.wdata);
    @(negedge clk);
    checkOutput({v.name, "/gnt"}, 32'(portGnt(v.port)), 32'd1);
    checkOutput({v.name, "/other_gnt"}, 32'(portGnt(!v.port)), 32'd0);
    checkOutput({v.name, "/t0_mem_en"}, 32'(mem_en), 32'(v.t0_en));
    if (v.t0_en) begin
      checkOutput({v.name, "/t0_mem_we"}, 32'(mem_we), 32'(v.t0_we));
      checkOutput({v.name, "/t0_mem_addr"}, 32'(mem_addr), 32'(v.addr[6:2]));
      if (v.t0_we) checkOutput({v.name, "/t0_mem_wdata"}, mem_wdata, v.wdata);
    end
    @(posedge clk); #1;
    drivePort(v.port, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput({v.name, "/t1_gnt"}, 32'({p1_if.gnt, p0_if.gnt}), 32'd0);
    checkOutput({v.name, "/t1_mem_en"}, 32'(mem_en), 32'(v.t1_en));
    if (v.t1_en) begin
      checkOutput({v.name, "/t1_mem_we"}, 32'(mem_we), 32'd1);
      checkOutput({v.name, "/t1_mem_addr"}, 32'(mem_addr), 32'(v.addr[6:2]));
      checkOutput({v.name, "/t1_mem_wdata"}, mem_wdata, v.t1_wdata);
    end
    checkOutput({v.name, "/rvalid"}, 32'(portRvalid(v.port)), 32'(v.t1_rvalid));
    checkOutput({v.name, "/err"}, 32'(portErr(v.port)), 32'(v.t1_err));
    checkOutput({v.name, "/rdata"}, portRdata(v.port), v.t1_rdata);
    checkOutput({v.name, "/other_rsp"}, 32'({portRvalid(!v.port), portErr(!v.port)}), 32'd0);
  endtask

  task automatic randReq(output bit we, output logic [3:0] be, output logic [31:0] addr,
                         output logic [31:0] wdata);
    int r;
    int k;
    r     = int'($urandom_range(0, 9));
    addr  = 32'($urandom_range(0, 23)) << 2;
    if (r == 0)      addr = addr | 32'($urandom_range(1, 3));
    else if (r == 1) addr = 32'h0000_1000 | addr;
    we    = 1'($urandom_range(0, 1));
    k     = int'($urandom_range(0, 5));
    if (k == 0)     be = 4'h0;
    else if (k < 3) be = 4'hF;
    else            be = 4'($urandom_range(1, 14));
    wdata = $urandom;
  endtask

  task automatic driveAll();
    for (int i = 0; i < 2; i++)
      drivePort(i[0], p_act[i], p_we[i], p_be[i], p_addr[i], p_wdata[i]);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with both ports already requesting loads; nothing may escape.
    rst = 1'b1;
    drivePort(1'b0, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
    drivePort(1'b1, 1'b1, 1'b0, 4'hF, 32'hC, 32'h0);
    for (int i = 0; i < 32; i++) preload_img[i] = 32'hA500_0000 | 32'(i);
    preload_img[3] = 32'h1122_3344;
    preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
    @(negedge clk);
    checkOutput("rst/gnt", 32'({p1_if.gnt, p0_if.gnt}), 32'd0);
    checkOutput("rst/rvalid", 32'({p1_if.rvalid, p0_if.rvalid}), 32'd0);
    checkOutput("rst/err", 32'({p1_if.err, p0_if.err}), 32'd0);
    checkOutput("rst/p0_rdata", p0_if.rdata, 32'h0);
    checkOutput("rst/p1_rdata", p1_if.rdata, 32'h0);
    checkOutput("rst/mem_ctl", 32'({mem_en, mem_we}), 32'd0);
    checkOutput("rst/mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst/mem_wdata", mem_wdata, 32'h0);

    // Continuous contention from reset: p0, p1, p0, ... one load every two cycles.
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("alt%0d/p0_gnt", k), 32'(p0_if.gnt), 32'(k % 4 == 0));
      checkOutput($sformatf("alt%0d/p1_gnt", k), 32'(p1_if.gnt), 32'(k % 4 == 2));
      checkOutput($sformatf("alt%0d/p0_rvalid", k), 32'(p0_if.rvalid), 32'(k % 4 == 1));
      checkOutput($sformatf("alt%0d/p1_rvalid", k), 32'(p1_if.rvalid), 32'(k % 4 == 3));
      checkOutput($sformatf("alt%0d/p0_rdata", k), p0_if.rdata, (k % 4 == 1) ? 32'hA500_0002 : 32'h0);
      checkOutput($sformatf("alt%0d/p1_rdata", k), p1_if.rdata, (k % 4 == 3) ? 32'h1122_3344 : 32'h0);
    end
    @(posedge clk); #1;
    drivePort(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drivePort(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // be=0 store is granted without a memory access and frees the next cycle.
    @(posedge clk); #1 drivePort(1'b0, 1'b1, 1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF);
    @(negedge clk);
    checkOutput("be0/gnt", 32'(p0_if.gnt), 32'd1);
    checkOutput("be0/mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1 drivePort(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    @(negedge clk);
    checkOutput("be0/next_gnt", 32'(p0_if.gnt), 32'd1);
    checkOutput("be0/next_rd", 32'({mem_en, mem_we}), 32'b10);
    checkOutput("be0/no_rsp", 32'({p0_if.rvalid, p0_if.err}), 32'd0);
    @(posedge clk); #1;
    drivePort(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drivePort(1'b1, 1'b1, 1'b1, 4'hF, 32'h18, 32'hCAFE_F00D);
    @(negedge clk);
    checkOutput("be0/rd_rvalid", 32'(p0_if.rvalid), 32'd1);
    checkOutput("be0/rd_rdata", p0_if.rdata, 32'hA500_0004);
    checkOutput("busy/p1_gnt", 32'(p1_if.gnt), 32'd0);

    // Back-to-back full stores, one per cycle.
    @(negedge clk);
    checkOutput("b2b0/gnt", 32'(p1_if.gnt), 32'd1);
    checkOutput("b2b0/wr", 32'({mem_en, mem_we}), 32'b11);
    checkOutput("b2b0/wdata", mem_wdata, 32'hCAFE_F00D);
    @(posedge clk); #1 drivePort(1'b1, 1'b1, 1'b1, 4'hF, 32'h1C, 32'h0BAD_C0DE);
    @(negedge clk);
    checkOutput("b2b1/gnt", 32'(p1_if.gnt), 32'd1);
    checkOutput("b2b1/wr", 32'({mem_en, mem_we}), 32'b11);
    checkOutput("b2b1/addr", 32'(mem_addr), 32'd7);
    checkOutput("b2b1/wdata", mem_wdata, 32'h0BAD_C0DE);
    @(posedge clk); #1 drivePort(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // name, port, we, be, addr, wdata, t0_en, t0_we, t1_en, t1_wdata, rvalid, err, rdata
    vecs.push_back(mkVec("st_full_w2", 0, 1, 4'hF, 32'h08, 32'hDEAD_BEEF, 1, 1, 0, 32'h0, 0, 0, 32'h0));
    vecs.push_back(mkVec("ld_w2",      0, 0, 4'hF, 32'h08, 32'h0,        1, 0, 0, 32'h0, 1, 0, 32'hDEAD_BEEF));
    vecs.push_back(mkVec("rmw_w3",     1, 1, 4'h5, 32'h0C, 32'hAABB_CCDD, 1, 0, 1, 32'h11BB_33DD, 0, 0, 32'h0));
    vecs.push_back(mkVec("ld_w3",      1, 0, 4'h0, 32'h0C, 32'h0,        1, 0, 0, 32'h0, 1, 0, 32'h11BB_33DD));
    vecs.push_back(mkVec("ld_oob20",   0, 0, 4'hF, 32'h50, 32'h0,        0, 0, 0, 32'h0, 1, 1, 32'h0));
    vecs.push_back(mkVec("st_misal",   1, 1, 4'hF, 32'h06, 32'h1234_5678, 0, 0, 0, 32'h0, 0, 1, 32'h0));
    vecs.push_back(mkVec("ld_w19",     1, 0, 4'hF, 32'h4C, 32'h0,        1, 0, 0, 32'h0, 1, 0, 32'hA500_0013));
    vecs.push_back(mkVec("rmw_w19",    0, 1, 4'h8, 32'h4C, 32'h7766_5544, 1, 0, 1, 32'h7700_0013, 0, 0, 32'h0));
    vecs.push_back(mkVec("ld_w19b",    0, 0, 4'hF, 32'h4C, 32'h0,        1, 0, 0, 32'h0, 1, 0, 32'h7700_0013));
    vecs.push_back(mkVec("ld_w6",      1, 0, 4'hF, 32'h18, 32'h0,        1, 0, 0, 32'h0, 1, 0, 32'hCAFE_F00D));
    vecs.push_back(mkVec("ld_w7",      0, 0, 4'hF, 32'h1C, 32'h0,        1, 0, 0, 32'h0, 1, 0, 32'h0BAD_C0DE));
    vecs.push_back(mkVec("ld_misal",   0, 0, 4'hF, 32'h03, 32'h0,        0, 0, 0, 32'h0, 1, 1, 32'h0));
    vecs.push_back(mkVec("ld_far",     1, 0, 4'hF, 32'h1000, 32'h0,      0, 0, 0, 32'h0, 1, 1, 32'h0));
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset during the merge-write cycle must drop the write.
    @(posedge clk); #1 drivePort(1'b0, 1'b1, 1'b1, 4'h3, 32'h14, 32'h1234_5678);
    @(negedge clk);
    checkOutput("rmwrst/gnt", 32'(p0_if.gnt), 32'd1);
    checkOutput("rmwrst/rd", 32'({mem_en, mem_we}), 32'b10);
    @(posedge clk); #1;
    drivePort(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rmwrst/mem_ctl", 32'({mem_en, mem_we}), 32'd0);
    checkOutput("rmwrst/mem_wdata", mem_wdata, 32'h0);
    checkOutput("rmwrst/p0_out", 32'({p0_if.gnt, p0_if.rvalid, p0_if.err}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    applyStimulus(mkVec("rmwrst_ld", 0, 0, 4'hF, 32'h14, 32'h0, 1, 0, 0, 32'h0, 1, 0, 32'hA500_0005));

    // Random traffic against a transaction-level model.
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) p_act[i] = 1'b0;
    driveAll();
    for (int i = 0; i < 32; i++) begin
      preload_img[i] = $urandom;
      ref_mem[i]     = preload_img[i];
    end
    preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    pref = 1'b0; cyc = 0; busy_until = 0; r_pend = 1'b0;
    for (int i = 0; i < 2; i++) begin
      randReq(p_we[i], p_be[i], p_addr[i], p_wdata[i]);
      p_act[i] = 1'($urandom_range(0, 1));
    end
    driveAll();
    for (int n = 0; n < 2000 && fails < 20; n++) begin
      @(negedge clk);
      exp_g = 2'b00;
      if (cyc >= busy_until) begin
        if (p_act[0] && p_act[1]) exp_g[pref] = 1'b1;
        else                      exp_g = {p_act[1], p_act[0]};
      end
      checkOutput($sformatf("rnd%0d/gnt", cyc), 32'({p1_if.gnt, p0_if.gnt}), 32'(exp_g));
      for (int p = 0; p < 2; p++) begin
        checkOutput($sformatf("rnd%0d/p%0d_rvalid", cyc, p), 32'(portRvalid(p[0])),
                    32'(r_pend && r_port == p[0] && r_valid));
        checkOutput($sformatf("rnd%0d/p%0d_err", cyc, p), 32'(portErr(p[0])),
                    32'(r_pend && r_port == p[0] && r_err));
        checkOutput($sformatf("rnd%0d/p%0d_rdata", cyc, p), portRdata(p[0]),
                    (r_pend && r_port == p[0] && r_valid) ? r_data : 32'h0);
      end
      r_pend = 1'b0;
      if (exp_g != 2'b00) begin
        w    = exp_g[1] ? 1 : 0;
        idx  = p_addr[w] >> 2;
        bad  = (p_addr[w][1:0] != 2'b00) || (idx >= 32'd20);
        mask = {{8{p_be[w][3]}}, {8{p_be[w][2]}}, {8{p_be[w][1]}}, {8{p_be[w][0]}}};
        busy_until = cyc + 2;
        if (bad) begin
          r_pend = 1'b1; r_port = w[0]; r_err = 1'b1; r_valid = !p_we[w]; r_data = 32'h0;
        end else if (!p_we[w]) begin
          r_pend = 1'b1; r_port = w[0]; r_err = 1'b0; r_valid = 1'b1; r_data = ref_mem[idx];
        end else begin
          ref_mem[idx] = (p_wdata[w] & mask) | (ref_mem[idx] & ~mask);
          if (p_be[w] == 4'hF || p_be[w] == 4'h0) busy_until = cyc + 1;
        end
        pref = (w == 0);
      end
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (exp_g[i]) begin
          randReq(p_we[i], p_be[i], p_addr[i], p_wdata[i]);
          p_act[i] = ($urandom_range(0, 3) != 0);
        end else if (!p_act[i]) begin
          randReq(p_we[i], p_be[i], p_addr[i], p_wdata[i]);
          p_act[i] = 1'($urandom_range(0, 1));
        end else if ($urandom_range(0, 15) == 0) begin
          p_act[i] = 1'b0;
        end
      end
      driveAll();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
